// File: rtl/cmp_arbiter_pkg.sv
// Shared processor definitions: operand width, compare opcode encoding and
// the result-register state type used by cmp_arbiter.
package cmp_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OpEq  = 3'b000,
        OpNe  = 3'b001,
        OpLt  = 3'b010,
        OpGe  = 3'b011,
        OpLtu = 3'b100,
        OpGeu = 3'b101,
        OpGt  = 3'b110,
        OpGtu = 3'b111
    } cmp_op_e;

    typedef enum logic {
        StEmpty,
        StFull
    } rsp_state_e;

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// 32-bit magnitude comparator: signed greater-than, unsigned greater-than
// and equality of a against b, purely combinational.
module cmp_arbiter_cmp
    import cmp_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt_s,
    output logic              gt_u,
    output logic              eq
);

    always_comb begin
        eq   = (a == b);
        gt_u = (a > b);
        gt_s = ($signed(a) > $signed(b));
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-requester arbiter in front of one shared comparator with a single
// registered result slot. Define CMP_ARB_RR_EN for round-robin arbitration.
module cmp_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req0_valid,
    output logic                             req0_ready,
    input  logic [cmp_arbiter_pkg::OP_W-1:0] req0_op,
    input  logic [DATA_W-1:0]                req0_a,
    input  logic [DATA_W-1:0]                req0_b,
    input  logic                             req1_valid,
    output logic                             req1_ready,
    input  logic [cmp_arbiter_pkg::OP_W-1:0] req1_op,
    input  logic [DATA_W-1:0]                req1_a,
    input  logic [DATA_W-1:0]                req1_b,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_id,
    output logic                             rsp_result
);
    import cmp_arbiter_pkg::*;

    rsp_state_e  state_q, state_d;
    logic        id_q, id_d;
    logic        result_q, result_d;
    logic [1:0]  grant;
    logic        can_accept;
    logic        accept;
    logic        sel;
    cmp_op_e     op_sel;
    logic [DATA_W-1:0] a_sel, b_sel;
    logic        gt_s, gt_u, eq;
    logic        cmp_out;

`ifdef CMP_ARB_RR_EN
    logic last_q, last_d;
`endif

    always_comb begin
        grant = 2'b00;
        if (req0_valid && req1_valid) begin
`ifdef CMP_ARB_RR_EN
            // last_q names the requester served most recently; favour the other.
            grant = last_q ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end else if (req0_valid) begin
            grant = 2'b01;
        end else if (req1_valid) begin
            grant = 2'b10;
        end
    end

    assign can_accept = (state_q == StEmpty) || rsp_ready;
    assign req0_ready = !rst && can_accept && grant[0];
    assign req1_ready = !rst && can_accept && grant[1];
    assign accept     = req0_ready || req1_ready;

    assign sel    = grant[1];
    assign op_sel = cmp_op_e'(sel ? req1_op : req0_op);
    assign a_sel  = sel ? req1_a : req0_a;
    assign b_sel  = sel ? req1_b : req0_b;

    cmp_arbiter_cmp u_cmp (
        .a    (a_sel),
        .b    (b_sel),
        .gt_s (gt_s),
        .gt_u (gt_u),
        .eq   (eq)
    );

    always_comb begin
        cmp_out = 1'b0;
        case (op_sel)
            OpEq:    cmp_out = eq;
            OpNe:    cmp_out = !eq;
            OpLt:    cmp_out = !gt_s && !eq;
            OpGe:    cmp_out = gt_s || eq;
            OpLtu:   cmp_out = !gt_u && !eq;
            OpGeu:   cmp_out = gt_u || eq;
            OpGt:    cmp_out = gt_s;
            OpGtu:   cmp_out = gt_u;
            default: cmp_out = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        result_d = result_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (rsp_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
        if (accept) begin
            id_d     = sel;
            result_d = cmp_out;
        end
    end

`ifdef CMP_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (accept) last_d = sel;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEmpty;
            id_q     <= 1'b0;
            result_q <= 1'b0;
`ifdef CMP_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            result_q <= result_d;
`ifdef CMP_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign rsp_valid  = (state_q == StFull);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized and directed bench for cmp_arbiter against a cycle-level
// reference model built from the compare and arbitration rules.
module tb_cmp_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_result;

    int n_checks = 0;
    int n_errors = 0;

    bit m_full = 1'b0;
    bit m_id   = 1'b0;
    bit m_res  = 1'b0;
    bit m_last = 1'b1;
    bit m_rst_seen = 1'b0;

    cmp_arbiter #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_cmp(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) < $signed(b);
            3'd3:    return $signed(a) >= $signed(b);
            3'd4:    return a < b;
            3'd5:    return a >= b;
            3'd6:    return $signed(a) > $signed(b);
            default: return a > b;
        endcase
    endfunction

    // One clock cycle: drive, check readies, clock, advance model, check response.
    task automatic step(input bit r,
                        input bit v0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit rr);
        bit g1, can, e0, e1;
        rst = r; rsp_ready = rr;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        #1;
`ifdef CMP_ARB_RR_EN
        g1 = (v0 && v1) ? !m_last : (!v0 && v1);
`else
        g1 = !v0 && v1;
`endif
        can = !m_full || rr;
        e0 = !r && can && (v0 || v1) && !g1;
        e1 = !r && can && (v0 || v1) && g1;
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        @(posedge clk);
        if (r) begin
            m_full = 0; m_id = 0; m_res = 0; m_last = 1; m_rst_seen = 1;
        end else if (e0 || e1) begin
            m_full = 1; m_id = g1; m_last = g1; m_rst_seen = 0;
            m_res = g1 ? ref_cmp(o1, a1, b1) : ref_cmp(o0, a0, b0);
        end else if (rr) begin
            m_full = 0;
        end
        #1;
        check("rsp_valid", rsp_valid, m_full);
        if (m_full || m_rst_seen) begin
            check("rsp_id", rsp_id, m_id);
            check("rsp_result", rsp_result, m_res);
        end
    endtask

    task automatic idle(input bit r, input bit rr);
        step(r, 0, 3'd0, 32'd0, 32'd0, 0, 3'd0, 32'd0, 32'd0, rr);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(5, 0))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit exp_seq [4];
        logic [31:0] a0, b0, a1, b1;
`ifdef CMP_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        rst = 1; rsp_ready = 0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        @(posedge clk); #1;
        idle(1, 0);
        idle(1, 1);
        check("reset_valid", rsp_valid, 0);

        // req0 LT signed: -1 < 1
        step(0, 1, 3'd2, 32'hFFFF_FFFF, 32'd1, 0, 3'd0, 32'd0, 32'd0, 1);
        check("lt_s_valid", rsp_valid, 1);
        check("lt_s_id", rsp_id, 0);
        check("lt_s_result", rsp_result, 1);
        // req1 LTU: 0xFFFFFFFF is not below 1
        step(0, 0, 3'd0, 32'd0, 32'd0, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 1);
        check("ltu_id", rsp_id, 1);
        check("ltu_result", rsp_result, 0);
        idle(0, 1);

        // Simultaneous requests from a fresh reset
        idle(1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 3'd0, 32'd1, 32'd1, 1, 3'd1, 32'd1, 32'd2, 1);
            check($sformatf("both_seq%0d", i), rsp_id, exp_seq[i]);
        end
        idle(0, 1);

        // Backpressure holds the result; then back-to-back after release
        idle(1, 1);
        step(0, 1, 3'd6, 32'd5, 32'd3, 0, 3'd0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 3'd0, 32'd7, 32'd9, 1, 3'd5, 32'd1, 32'd2, 0);
            check("hold_result", rsp_result, 1);
            check("hold_id", rsp_id, 0);
        end
        step(0, 1, 3'd0, 32'd4, 32'd4, 0, 3'd0, 32'd0, 32'd0, 1);
        check("b2b_valid", rsp_valid, 1);
        check("b2b_result", rsp_result, 1);

        step(0, 1, 3'd0, 32'h1234_5678, 32'h1234_5678, 0, 3'd0, 32'd0, 32'd0, 1);
        check("eq_equal", rsp_result, 1);
        step(0, 1, 3'd1, 32'h1234_5678, 32'h1234_5678, 0, 3'd0, 32'd0, 32'd0, 1);
        check("ne_equal", rsp_result, 0);
        step(0, 1, 3'd6, 32'h8000_0000, 32'h7FFF_FFFF, 0, 3'd0, 32'd0, 32'd0, 1);
        check("gt_s_min", rsp_result, 0);
        step(0, 1, 3'd2, 32'h8000_0000, 32'h7FFF_FFFF, 0, 3'd0, 32'd0, 32'd0, 1);
        check("lt_s_min", rsp_result, 1);
        step(0, 0, 3'd0, 32'd0, 32'd0, 1, 3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 1);
        check("ltu_min", rsp_result, 0);
        idle(0, 1);

        // Reset while FULL drops the pending result
        step(0, 1, 3'd0, 32'd3, 32'd3, 0, 3'd0, 32'd0, 32'd0, 0);
        check("pre_rst_full", rsp_valid, 1);
        step(1, 1, 3'd0, 32'd3, 32'd3, 1, 3'd0, 32'd3, 32'd3, 0);
        check("rst_drop", rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            idle(0, 1);
            check("no_ghost", rsp_valid, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            a0 = pick_operand();
            b0 = ($urandom_range(3, 0) == 0) ? a0 : pick_operand();
            a1 = pick_operand();
            b1 = ($urandom_range(3, 0) == 0) ? a1 : pick_operand();
            step(($urandom_range(63, 0) == 0),
                 1'($urandom), 3'($urandom), a0, b0,
                 1'($urandom), 3'($urandom), a1, b1,
                 ($urandom_range(3, 0) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
